execute_stage: RTL and testbench

- Pipeline consumer of the decode/execute register in the 5-stage RV32I core.
- Takes the registered control and datapath fields from decode and resolves operand forwarding from the memory and writeback stages.
- Performs the ALU operation and resolves branches and jumps, driving the redirect to fetch.
- Registers its results into the execute/memory pipeline register. Single clock domain.

---
 rtl/execute_stage.sv | 107 ++++++++++
 tb/tb_execute_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding from the
// memory and writeback stages, ALU, branch/jump resolution and the E/M
// pipeline register. There is no handshake: every clock edge advances the
// pipeline, and a flushed slot arrives as an all-zero bubble.
module execute_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [XLEN-1:0]   pc_e,
    input  logic [XLEN-1:0]   pc_plus4_e,
    input  logic              jump_e,
    input  logic              branch_e,
    input  logic [1:0]        result_src_e,
    input  logic              mem_write_e,
    input  logic              alu_src_e,
    input  logic              reg_write_e,
    input  logic [2:0]        alu_control_e,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [XLEN-1:0]   rd1_e,
    input  logic [XLEN-1:0]   rd2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [XLEN-1:0]   imm_ext_e,
    input  logic              reg_write_w,
    input  logic [REG_AW-1:0] rd_w,
    input  logic [XLEN-1:0]   result_w,
    output logic              pc_src_e,
    output logic [XLEN-1:0]   pc_target_e,
    output logic [XLEN-1:0]   alu_result_m,
    output logic [XLEN-1:0]   write_data_m,
    output logic [REG_AW-1:0] rd_m,
    output logic [XLEN-1:0]   pc_plus4_m,
    output logic              reg_write_m,
    output logic              mem_write_m,
    output logic [1:0]        result_src_m
);

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    // Operand A: memory stage has priority over writeback; x0 never forwards.
    always_comb begin
        src_a = rd1_e;
        if (rs1_e != '0 && reg_write_m && rd_m == rs1_e)
            src_a = alu_result_m;
        else if (rs1_e != '0 && reg_write_w && rd_w == rs1_e)
            src_a = result_w;
    end

    // Operand B register path, same priority; this is also the store data.
    always_comb begin
        fwd_b = rd2_e;
        if (rs2_e != '0 && reg_write_m && rd_m == rs2_e)
            fwd_b = alu_result_m;
        else if (rs2_e != '0 && reg_write_w && rd_w == rs2_e)
            fwd_b = result_w;
    end

    assign src_b = alu_src_e ? imm_ext_e : fwd_b;

    // ALU: wrapping arithmetic, shift amount from the low five bits of B.
    always_comb begin
        alu_result = '0;
        case (alu_control_e)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a ^ src_b;
            3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b110:  alu_result = src_a << src_b[4:0];
            default: alu_result = src_a >> src_b[4:0];
        endcase
    end

    assign zero        = (alu_result == '0);
    assign pc_target_e = pc_e + imm_ext_e;
    // Redirect is suppressed during reset so fetch never follows garbage.
    assign pc_src_e    = ~srst & (jump_e | (branch_e & zero));

    // E/M pipeline register; reset discards the in-flight instruction.
    always_ff @(posedge clk) begin
        if (srst) begin
            alu_result_m <= '0;
            write_data_m <= '0;
            rd_m         <= '0;
            pc_plus4_m   <= '0;
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= 2'b00;
        end else begin
            alu_result_m <= alu_result;
            write_data_m <= fwd_b;
            rd_m         <= rd_e;
            pc_plus4_m   <= pc_plus4_e;
            reg_write_m  <= reg_write_e;
            mem_write_m  <= mem_write_e;
            result_src_m <= result_src_e;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: constant-vector ALU sweep, hand-written forwarding,
// branch, store, bubble and reset sequences, then randomized traffic checked
// against a behavioural model of the execute stage.
module tb_execute_stage;

    logic        clk;
    logic        srst;
    logic [31:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_ext_e, result_w;
    logic        jump_e, branch_e, mem_write_e, alu_src_e, reg_write_e, reg_write_w;
    logic [1:0]  result_src_e;
    logic [2:0]  alu_control_e;
    logic [4:0]  rs1_e, rs2_e, rd_e, rd_w;
    logic        pc_src_e;
    logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
    logic [4:0]  rd_m;
    logic        reg_write_m, mem_write_m;
    logic [1:0]  result_src_m;

    int tests_run = 0;
    int tests_failed = 0;

    execute_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk(clk), .srst(srst), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .jump_e(jump_e), .branch_e(branch_e), .result_src_e(result_src_e),
        .mem_write_e(mem_write_e), .alu_src_e(alu_src_e), .reg_write_e(reg_write_e),
        .alu_control_e(alu_control_e), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .rd_e(rd_e), .imm_ext_e(imm_ext_e),
        .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
        .alu_result_m(alu_result_m), .write_data_m(write_data_m), .rd_m(rd_m),
        .pc_plus4_m(pc_plus4_m), .reg_write_m(reg_write_m),
        .mem_write_m(mem_write_m), .result_src_m(result_src_m)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        srst;
        logic [31:0] pc, pc4;
        logic        jump, branch;
        logic [1:0]  rsrc;
        logic        mw, asrc, rw;
        logic [2:0]  op;
        logic [4:0]  rs1, rs2;
        logic [31:0] rd1, rd2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        rw_w;
        logic [4:0]  rd_w;
        logic [31:0] res_w;
    } in_t;

    // Model of what the memory stage holds after each edge
    typedef struct packed {
        logic [31:0] alu, wd;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic        rw, mw;
        logic [1:0]  rsrc;
    } m_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] exp;
    } alu_vec_t;

    m_t       em;
    alu_vec_t alu_tab [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    // Value a source register sees: youngest producer wins, x0 is constant.
    function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] raw, input in_t v);
        if (rs == 0) return raw;
        if (em.rw && em.rd == rs) return em.alu;
        if (v.rw_w && v.rd_w == rs) return v.res_w;
        return raw;
    endfunction

    task automatic apply(input in_t v);
        srst = v.srst; pc_e = v.pc; pc_plus4_e = v.pc4; jump_e = v.jump;
        branch_e = v.branch; result_src_e = v.rsrc; mem_write_e = v.mw;
        alu_src_e = v.asrc; reg_write_e = v.rw; alu_control_e = v.op;
        rs1_e = v.rs1; rs2_e = v.rs2; rd1_e = v.rd1; rd2_e = v.rd2; rd_e = v.rd;
        imm_ext_e = v.imm; reg_write_w = v.rw_w; rd_w = v.rd_w; result_w = v.res_w;
    endtask

    // Drive one instruction for one cycle, check redirect, then the E/M register.
    task automatic run_cycle(input in_t v);
        logic [31:0] a, b_reg, b, res;
        logic        take;
        apply(v);
        #3;
        a     = operand(v.rs1, v.rd1, v);
        b_reg = operand(v.rs2, v.rd2, v);
        b     = v.asrc ? v.imm : b_reg;
        res   = ref_alu(v.op, a, b);
        take  = !v.srst && (v.jump || (v.branch && res == 0));
        check("pc_src_e", {31'd0, pc_src_e}, {31'd0, take});
        check("pc_target_e", pc_target_e, v.pc + v.imm);
        @(posedge clk);
        #1;
        if (v.srst) em = '0;
        else em = '{alu: res, wd: b_reg, rd: v.rd, pc4: v.pc4, rw: v.rw, mw: v.mw, rsrc: v.rsrc};
        check("alu_result_m", alu_result_m, em.alu);
        check("write_data_m", write_data_m, em.wd);
        check("rd_m", {27'd0, rd_m}, {27'd0, em.rd});
        check("pc_plus4_m", pc_plus4_m, em.pc4);
        check("reg_write_m", {31'd0, reg_write_m}, {31'd0, em.rw});
        check("mem_write_m", {31'd0, mem_write_m}, {31'd0, em.mw});
        check("result_src_m", {30'd0, result_src_m}, {30'd0, em.rsrc});
    endtask

    // Producer of value val into register rd (add of rd1 + 0 immediate).
    function automatic in_t producer(input logic [4:0] rd, input logic [31:0] val);
        in_t v;
        v = '0;
        v.rw = 1'b1; v.rd = rd; v.rd1 = val; v.asrc = 1'b1; v.pc4 = 32'h4;
        return v;
    endfunction

    initial begin
        in_t v;
        em = '0;
        apply('0);
        alu_tab[0] = '{op: 3'd0, exp: 32'h0000_0010};
        alu_tab[1] = '{op: 3'd1, exp: 32'hFFFF_FFD0};
        alu_tab[2] = '{op: 3'd2, exp: 32'h0000_0020};
        alu_tab[3] = '{op: 3'd3, exp: 32'hFFFF_FFF0};
        alu_tab[4] = '{op: 3'd4, exp: 32'hFFFF_FFD0};
        alu_tab[5] = '{op: 3'd5, exp: 32'h0000_0001};
        alu_tab[6] = '{op: 3'd6, exp: 32'hFFFF_FFF0};
        alu_tab[7] = '{op: 3'd7, exp: 32'hFFFF_FFF0};
        @(posedge clk);
        #1;

        // Reset with busy, nonzero inputs (including a jump)
        v = '{srst: 1'b1, pc: 32'h200, pc4: 32'h204, jump: 1'b1, branch: 1'b1,
              rsrc: 2'b10, mw: 1'b1, asrc: 1'b0, rw: 1'b1, op: 3'd3, rs1: 5'd1,
              rs2: 5'd2, rd1: 32'h1234, rd2: 32'h55, rd: 5'd7, imm: 32'h10,
              rw_w: 1'b1, rd_w: 5'd3, res_w: 32'h99};
        for (int i = 0; i < 2; i++) run_cycle(v);
        check("reset_rw", {31'd0, reg_write_m}, 32'd0);
        v.srst = 1'b0; v.jump = 1'b0; v.branch = 1'b0;
        run_cycle(v);
        check("post_reset_alu", alu_result_m, 32'h1234 | 32'h55);

        // ALU sweep from the constant table
        for (int i = 0; i < 8; i++) begin
            v = '0;
            v.rd1 = 32'hFFFF_FFF0; v.rd2 = 32'h0000_0020; v.op = alu_tab[i].op;
            run_cycle(v);
            check($sformatf("alu_op%0d", i), alu_result_m, alu_tab[i].exp);
        end

        // Forward priority: M over W, then W alone, then x0 ignores both
        run_cycle(producer(5'd5, 32'h11));
        v = '0;
        v.rs1 = 5'd5; v.rd1 = 32'h99; v.asrc = 1'b1;
        v.rw_w = 1'b1; v.rd_w = 5'd5; v.res_w = 32'h22;
        run_cycle(v);
        check("fwd_m_over_w", alu_result_m, 32'h11);
        run_cycle(v);
        check("fwd_w_only", alu_result_m, 32'h22);
        run_cycle(producer(5'd0, 32'h11));
        v.rs1 = 5'd0; v.rd_w = 5'd0;
        run_cycle(v);
        check("fwd_x0", alu_result_m, 32'h99);

        // beq with equal forwarded operands: A from M, B from W
        run_cycle(producer(5'd3, 32'h55));
        v = '0;
        v.branch = 1'b1; v.op = 3'd1; v.pc = 32'h100; v.imm = 32'h40;
        v.rs1 = 5'd3; v.rs2 = 5'd4; v.rd1 = 32'h0; v.rd2 = 32'h1;
        v.rw_w = 1'b1; v.rd_w = 5'd4; v.res_w = 32'h55;
        apply(v);
        #3;
        check("beq_taken", {31'd0, pc_src_e}, 32'd1);
        check("beq_target", pc_target_e, 32'h140);
        run_cycle(v);
        // Unequal operands, no forwarding
        v = '0;
        v.branch = 1'b1; v.op = 3'd1; v.pc = 32'h100; v.imm = 32'h40;
        v.rd1 = 32'h7; v.rd2 = 32'h8;
        apply(v);
        #3;
        check("beq_not_taken", {31'd0, pc_src_e}, 32'd0);
        run_cycle(v);
        v.branch = 1'b0; v.jump = 1'b1;
        apply(v);
        #3;
        check("jal_taken", {31'd0, pc_src_e}, 32'd1);
        run_cycle(v);

        // Store: immediate offset, store data forwarded from W
        v = '0;
        v.mw = 1'b1; v.asrc = 1'b1; v.imm = 32'd8; v.rd1 = 32'h1000;
        v.rs2 = 5'd7; v.rd2 = 32'h1; v.rw_w = 1'b1; v.rd_w = 5'd7; v.res_w = 32'hDEAD_BEEF;
        run_cycle(v);
        check("store_data", write_data_m, 32'hDEAD_BEEF);
        check("store_addr", alu_result_m, 32'h1008);

        // Bubble after a writer: no write, no later M forward
        run_cycle(producer(5'd9, 32'h77));
        run_cycle('0);
        check("bubble_rw", {31'd0, reg_write_m}, 32'd0);
        check("bubble_mw", {31'd0, mem_write_m}, 32'd0);
        v = '0;
        v.rs1 = 5'd9; v.rd1 = 32'h3; v.asrc = 1'b1;
        run_cycle(v);
        check("bubble_no_fwd", alu_result_m, 32'h3);

        // Reset mid-stream discards the in-flight writer
        run_cycle(producer(5'd6, 32'hAB));
        v = '0; v.srst = 1'b1;
        run_cycle(v);
        v = '0;
        v.rs1 = 5'd6; v.rd1 = 32'h5; v.asrc = 1'b1;
        run_cycle(v);
        check("reset_no_fwd", alu_result_m, 32'h5);

        // Randomized traffic with small register indices to provoke forwarding
        for (int i = 0; i < 400; i++) begin
            v.srst   = ($urandom_range(0, 19) == 0);
            v.pc     = $urandom; v.pc4 = v.pc + 4;
            v.jump   = ($urandom_range(0, 7) == 0);
            v.branch = $urandom_range(0, 1);
            v.rsrc   = 2'($urandom_range(0, 3));
            v.mw     = $urandom_range(0, 1);
            v.asrc   = $urandom_range(0, 1);
            v.rw     = $urandom_range(0, 1);
            v.op     = 3'($urandom_range(0, 7));
            v.rs1    = 5'($urandom_range(0, 3));
            v.rs2    = 5'($urandom_range(0, 3));
            v.rd1    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            v.rd2    = ($urandom_range(0, 3) == 0) ? v.rd1 : $urandom;
            v.rd     = 5'($urandom_range(0, 3));
            v.imm    = $urandom;
            v.rw_w   = $urandom_range(0, 1);
            v.rd_w   = 5'($urandom_range(0, 3));
            v.res_w  = $urandom;
            run_cycle(v);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
